// File: rtl/iiitb_lifo_ctrl.sv
// iiitb_lifo_ctrl
// Stream-to-LIFO initiator: collects a packet of up to DEPTH words from a
// valid/ready input stream, pushes them into an external iiitb_lifo, then
// pops them back out and presents them on a valid/ready output stream in
// reversed order. The LIFO-facing signals are decoded combinationally from
// the controller state so the LIFO samples them on the following clock edge.
module iiitb_lifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err,
  output logic [DATA_W-1:0] lifo_dataIn,
  output logic              lifo_RW,
  output logic              lifo_EN,
  output logic              lifo_Rst,
  input  logic [DATA_W-1:0] lifo_dataOut,
  input  logic              lifo_EMPTY,
  input  logic              lifo_FULL
);

  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  // INIT clears the LIFO, FILL pushes, POP issues one pop, OUT presents it.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    POP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_zero;
  logic             push_ok;
  logic             accept;
  logic             status_bad;

  // The LIFO's own FULL flag is undefined right after its reset, so the
  // occupancy count is tracked locally and FULL is deliberately ignored.
  logic             full_unused;
  assign full_unused = lifo_FULL;

  assign cnt_inc    = cnt + 1'b1;
  assign cnt_zero   = (cnt == '0);
  assign push_ok    = (state == FILL) && (cnt < DEPTH_C);
  assign accept     = push_ok && in_valid;
  // In OUT the LIFO has been popped down to exactly cnt words, so EMPTY must
  // agree with cnt==0; any disagreement means the two views have diverged.
  assign status_bad = (lifo_EMPTY != cnt_zero);

  // State, occupancy count and sticky error flag.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= INIT;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= FILL;
        end
        FILL: begin
          if (accept) begin
            cnt <= cnt_inc;
            // A packet closes on an accepted last word or when the LIFO fills.
            if (in_last || (cnt_inc == DEPTH_C)) begin
              state <= POP;
            end
          end
        end
        POP: begin
          cnt   <= cnt - 1'b1;
          state <= OUT;
        end
        OUT: begin
          if (status_bad) begin
            err <= 1'b1;
          end
          if (out_ready) begin
            state <= cnt_zero ? FILL : POP;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Stream handshakes and LIFO command decode from the current state.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    lifo_dataIn = '0;
    lifo_RW     = 1'b0;
    lifo_EN     = 1'b0;
    lifo_Rst    = 1'b0;
    case (state)
      INIT: begin
        lifo_EN  = 1'b1;
        lifo_Rst = 1'b1;
      end
      FILL: begin
        in_ready = push_ok;
        if (accept) begin
          lifo_EN     = 1'b1;
          lifo_RW     = 1'b0;
          lifo_dataIn = in_data;
        end
      end
      POP: begin
        lifo_EN = 1'b1;
        lifo_RW = 1'b1;
      end
      OUT: begin
        // EN stays low so the LIFO keeps dataOut steady while we wait.
        out_valid = 1'b1;
        out_data  = lifo_dataOut;
        out_last  = cnt_zero;
      end
      default: begin
        lifo_EN = 1'b0;
      end
    endcase
  end

endmodule
